// File: rtl/lockon_track_manager.sv
// rtl/lockon_track_manager.sv - gated nearest-distance multi-target tracker with per-slot lock FSM
module lockon_track_manager #(
  parameter int NUM_TRACKS   = 4,
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int GATE         = 8,
  parameter int LOCK_FRAMES  = 3,
  parameter int COAST_FRAMES = 4,
  parameter int SMOOTH       = 0,
  localparam int IDX_W       = $clog2(NUM_TRACKS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             det_valid,
  output logic             det_ready,
  input  logic [X_W-1:0]   det_x,
  input  logic [Y_W-1:0]   det_y,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic [1:0]       rd_state,
  output logic [X_W-1:0]   tgt_x,
  output logic [Y_W-1:0]   tgt_y,
  output logic             tgt_valid,
  output logic             lock_on,
  output logic [3:0]       num_locked,
  output logic [7:0]       drop_cnt
);

  // Distance wide enough that |dx|+|dy| never wraps.
  localparam int D_W = ((X_W > Y_W) ? X_W : Y_W) + 1;

  typedef enum logic [1:0] {S_FREE = 2'd0, S_TENT = 2'd1, S_LOCKED = 2'd2, S_COAST = 2'd3} slot_state_e;
  typedef enum logic [1:0] {C_IDLE, C_SCAN, C_COMMIT, C_UPDATE} ctrl_e;

  ctrl_e            ctrl_q;
  logic             frame_pend_q;
  logic [X_W-1:0]   det_x_q;
  logic [Y_W-1:0]   det_y_q;
  logic [IDX_W-1:0] scan_idx_q;
  logic             best_found_q;
  logic [IDX_W-1:0] best_idx_q;
  logic [D_W-1:0]   best_dist_q;
  logic             free_found_q;
  logic [IDX_W-1:0] free_idx_q;

  slot_state_e      slot_state_q [NUM_TRACKS];
  logic [X_W-1:0]   slot_x_q     [NUM_TRACKS];
  logic [Y_W-1:0]   slot_y_q     [NUM_TRACKS];
  logic [3:0]       hit_cnt_q    [NUM_TRACKS];
  logic [3:0]       miss_cnt_q   [NUM_TRACKS];
  logic             hit_flag_q   [NUM_TRACKS];
  logic             alloc_flag_q [NUM_TRACKS];

  logic [7:0]       drop_cnt_q;
  logic [X_W-1:0]   tgt_x_q;
  logic [Y_W-1:0]   tgt_y_q;
  logic             tgt_valid_q;
  logic             lock_on_q;
  logic [3:0]       num_locked_q;
  logic [X_W-1:0]   rd_x_q;
  logic [Y_W-1:0]   rd_y_q;
  logic [1:0]       rd_state_q;

  logic [X_W-1:0]   scan_dx;
  logic [Y_W-1:0]   scan_dy;
  logic [D_W-1:0]   scan_dist;
  logic             scan_cand;
  logic             scan_better;
  logic [X_W:0]     sum_x;
  logic [Y_W:0]     sum_y;
  logic [X_W-1:0]   hit_x_d;
  logic [Y_W-1:0]   hit_y_d;

  slot_state_e      state_upd_d [NUM_TRACKS];
  logic [3:0]       hit_upd_d   [NUM_TRACKS];
  logic [3:0]       miss_upd_d  [NUM_TRACKS];
  logic [3:0]       miss_n;
  logic [3:0]       num_locked_d;
  logic             tgt_found_d;
  logic [3:0]       tgt_best_hit;
  logic [X_W-1:0]   tgt_x_d;
  logic [Y_W-1:0]   tgt_y_d;

  assign det_ready  = (ctrl_q == C_IDLE) && !frame_pend_q && !frame_start && !reset;
  assign rd_x       = rd_x_q;
  assign rd_y       = rd_y_q;
  assign rd_state   = rd_state_q;
  assign tgt_x      = tgt_x_q;
  assign tgt_y      = tgt_y_q;
  assign tgt_valid  = tgt_valid_q;
  assign lock_on    = lock_on_q;
  assign num_locked = num_locked_q;
  assign drop_cnt   = drop_cnt_q;

  // Distance of the slot under scan and the position a hit on the best slot would take.
  always_comb begin
    scan_dx     = (slot_x_q[scan_idx_q] >= det_x_q) ? slot_x_q[scan_idx_q] - det_x_q
                                                    : det_x_q - slot_x_q[scan_idx_q];
    scan_dy     = (slot_y_q[scan_idx_q] >= det_y_q) ? slot_y_q[scan_idx_q] - det_y_q
                                                    : det_y_q - slot_y_q[scan_idx_q];
    scan_dist   = D_W'(scan_dx) + D_W'(scan_dy);
    scan_cand   = (slot_state_q[scan_idx_q] != S_FREE) && !hit_flag_q[scan_idx_q] &&
                  (32'(scan_dist) <= GATE);
    scan_better = scan_cand && (!best_found_q || (scan_dist < best_dist_q));
    sum_x       = {1'b0, slot_x_q[best_idx_q]} + {1'b0, det_x_q};
    sum_y       = {1'b0, slot_y_q[best_idx_q]} + {1'b0, det_y_q};
    hit_x_d     = (SMOOTH != 0) ? sum_x[X_W:1] : det_x_q;
    hit_y_d     = (SMOOTH != 0) ? sum_y[Y_W:1] : det_y_q;
  end

  // Frame-boundary slot transitions and primary target selection from the post-update state.
  always_comb begin
    miss_n       = '0;
    num_locked_d = '0;
    tgt_found_d  = 1'b0;
    tgt_best_hit = '0;
    tgt_x_d      = tgt_x_q;
    tgt_y_d      = tgt_y_q;
    for (int i = 0; i < NUM_TRACKS; i++) begin
      state_upd_d[i] = slot_state_q[i];
      hit_upd_d[i]   = hit_cnt_q[i];
      miss_upd_d[i]  = miss_cnt_q[i];
      miss_n         = (miss_cnt_q[i] == 4'd15) ? 4'd15 : miss_cnt_q[i] + 4'd1;
      if (hit_flag_q[i]) begin
        // A slot born this frame already carries its first hit.
        if (!alloc_flag_q[i]) begin
          hit_upd_d[i] = (hit_cnt_q[i] == 4'd15) ? 4'd15 : hit_cnt_q[i] + 4'd1;
        end
        miss_upd_d[i] = '0;
        if ((slot_state_q[i] == S_COAST) ||
            ((slot_state_q[i] == S_TENT) && (32'(hit_upd_d[i]) >= LOCK_FRAMES))) begin
          state_upd_d[i] = S_LOCKED;
        end
      end else begin
        case (slot_state_q[i])
          S_TENT: begin
            state_upd_d[i] = S_FREE;
            hit_upd_d[i]   = '0;
            miss_upd_d[i]  = '0;
          end
          S_LOCKED: begin
            state_upd_d[i] = S_COAST;
            miss_upd_d[i]  = 4'd1;
          end
          S_COAST: begin
            if (32'(miss_n) >= COAST_FRAMES) begin
              state_upd_d[i] = S_FREE;
              hit_upd_d[i]   = '0;
              miss_upd_d[i]  = '0;
            end else begin
              miss_upd_d[i]  = miss_n;
            end
          end
          default: ;
        endcase
      end
      if (state_upd_d[i] == S_LOCKED) begin
        num_locked_d = num_locked_d + 4'd1;
      end
      if (((state_upd_d[i] == S_LOCKED) || (state_upd_d[i] == S_COAST)) &&
          (!tgt_found_d || (hit_upd_d[i] > tgt_best_hit))) begin
        tgt_found_d  = 1'b1;
        tgt_best_hit = hit_upd_d[i];
        tgt_x_d      = slot_x_q[i];
        tgt_y_d      = slot_y_q[i];
      end
    end
  end

  // Control FSM, slot table, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q       <= C_IDLE;
      frame_pend_q <= 1'b0;
      det_x_q      <= '0;
      det_y_q      <= '0;
      scan_idx_q   <= '0;
      best_found_q <= 1'b0;
      best_idx_q   <= '0;
      best_dist_q  <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      drop_cnt_q   <= '0;
      tgt_x_q      <= '0;
      tgt_y_q      <= '0;
      tgt_valid_q  <= 1'b0;
      lock_on_q    <= 1'b0;
      num_locked_q <= '0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
      rd_state_q   <= '0;
      for (int i = 0; i < NUM_TRACKS; i++) begin
        slot_state_q[i] <= S_FREE;
        slot_x_q[i]     <= '0;
        slot_y_q[i]     <= '0;
        hit_cnt_q[i]    <= '0;
        miss_cnt_q[i]   <= '0;
        hit_flag_q[i]   <= 1'b0;
        alloc_flag_q[i] <= 1'b0;
      end
    end else begin
      rd_x_q     <= slot_x_q[rd_idx];
      rd_y_q     <= slot_y_q[rd_idx];
      rd_state_q <= slot_state_q[rd_idx];
      case (ctrl_q)
        C_IDLE: begin
          if (frame_start || frame_pend_q) begin
            frame_pend_q <= 1'b0;
            ctrl_q       <= C_UPDATE;
          end else if (det_valid) begin
            det_x_q      <= det_x;
            det_y_q      <= det_y;
            scan_idx_q   <= '0;
            best_found_q <= 1'b0;
            best_idx_q   <= '0;
            best_dist_q  <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            ctrl_q       <= C_SCAN;
          end
        end
        C_SCAN: begin
          if (frame_start) begin
            frame_pend_q <= 1'b1;
          end
          if (scan_better) begin
            best_found_q <= 1'b1;
            best_idx_q   <= scan_idx_q;
            best_dist_q  <= scan_dist;
          end
          if (!free_found_q && (slot_state_q[scan_idx_q] == S_FREE)) begin
            free_found_q <= 1'b1;
            free_idx_q   <= scan_idx_q;
          end
          if (scan_idx_q == IDX_W'(NUM_TRACKS - 1)) begin
            ctrl_q <= C_COMMIT;
          end else begin
            scan_idx_q <= scan_idx_q + 1'b1;
          end
        end
        C_COMMIT: begin
          if (best_found_q) begin
            hit_flag_q[best_idx_q] <= 1'b1;
            slot_x_q[best_idx_q]   <= hit_x_d;
            slot_y_q[best_idx_q]   <= hit_y_d;
          end else if (free_found_q) begin
            slot_state_q[free_idx_q] <= S_TENT;
            slot_x_q[free_idx_q]     <= det_x_q;
            slot_y_q[free_idx_q]     <= det_y_q;
            hit_cnt_q[free_idx_q]    <= 4'd1;
            miss_cnt_q[free_idx_q]   <= '0;
            hit_flag_q[free_idx_q]   <= 1'b1;
            alloc_flag_q[free_idx_q] <= 1'b1;
          end else if (drop_cnt_q != 8'd255) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
          end
          if (frame_pend_q) begin
            frame_pend_q <= 1'b0;
            ctrl_q       <= C_UPDATE;
          end else begin
            if (frame_start) begin
              frame_pend_q <= 1'b1;
            end
            ctrl_q <= C_IDLE;
          end
        end
        C_UPDATE: begin
          frame_pend_q <= frame_start;
          for (int i = 0; i < NUM_TRACKS; i++) begin
            slot_state_q[i] <= state_upd_d[i];
            hit_cnt_q[i]    <= hit_upd_d[i];
            miss_cnt_q[i]   <= miss_upd_d[i];
            hit_flag_q[i]   <= 1'b0;
            alloc_flag_q[i] <= 1'b0;
          end
          tgt_valid_q  <= tgt_found_d;
          tgt_x_q      <= tgt_x_d;
          tgt_y_q      <= tgt_y_d;
          lock_on_q    <= (num_locked_d != 4'd0);
          num_locked_q <= num_locked_d;
          ctrl_q       <= C_IDLE;
        end
        default: ctrl_q <= C_IDLE;
      endcase
    end
  end

endmodule
